// File: rtl/mem_pattern_tester.sv
// Memory pattern tester: it makes repeated write-then-readback passes over the
// word range 0..addr_last through a single-outstanding request/ack memory port.
module mem_pattern_tester #(
  parameter int          DATA_W    = 16,
  parameter int          ADDR_W    = 22,
  parameter logic [31:0] LFSR_SEED = 32'h1D872B41
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_last,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [31:0]       passcount,
  output logic [31:0]       failcount,
  output logic              first_fail_valid,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic [DATA_W-1:0] first_fail_xor,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_START    = 4'd1,
    S_WR       = 4'd2,
    S_RD_SEED  = 4'd3,
    S_RD       = 4'd4,
    S_PASS_END = 4'd5
  } state_t;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;
  localparam int          REPS      = (DATA_W + 31) / 32;
  localparam int          CHK_N     = (DATA_W + 1) / 2;
  localparam logic [2*CHK_N-1:0] CHK_EVEN = {CHK_N{2'b01}};
  localparam logic [2*CHK_N-1:0] CHK_ODD  = {CHK_N{2'b10}};

  // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    lfsr_step = {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                input logic [ADDR_W-1:0] a,
                                                input logic [31:0]       lf,
                                                input logic              inv);
    logic [DATA_W+ADDR_W-1:0] ext;
    logic [REPS*32-1:0]       rep;
    logic [63:0]              a64;
    logic [DATA_W-1:0]        p;
    ext = {{DATA_W{1'b0}}, a};
    rep = {REPS{lf}};
    a64 = 64'(a);
    case (m)
      2'd0:    p = ext[DATA_W-1:0];
      2'd1:    p = DATA_W'(1) << (a64 % 64'(DATA_W));
      2'd2:    p = rep[DATA_W-1:0];
      default: p = a[0] ? CHK_ODD[DATA_W-1:0] : CHK_EVEN[DATA_W-1:0];
    endcase
    pattern = p ^ {DATA_W{inv}};
  endfunction

  state_t            state_q, state_d;
  logic              run_q, run_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_last_q, addr_last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic              inv_q, inv_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       passcount_q, passcount_d;
  logic [31:0]       failcount_q, failcount_d;
  logic              ff_valid_q, ff_valid_d;
  logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
  logic [DATA_W-1:0] ff_xor_q, ff_xor_d;
  logic              at_last;
  logic              mismatch;

  always_comb begin
    state_d     = state_q;
    run_d       = run;
    mode_d      = mode_q;
    addr_last_d = addr_last_q;
    addr_d      = addr_q;
    lfsr_d      = lfsr_q;
    inv_d       = inv_q;
    passcount_d = passcount_q;
    failcount_d = failcount_q;
    ff_valid_d  = ff_valid_q;
    ff_addr_d   = ff_addr_q;
    ff_xor_d    = ff_xor_q;
    at_last     = (addr_q == addr_last_q);
    // pat_q always holds the pattern for addr_q, so it is both write data and read expectation.
    mismatch    = (mem_rdata != pat_q);

    case (state_q)
      S_IDLE: begin
        if (run && !run_q) begin
          mode_d      = mode;
          addr_last_d = addr_last;
          passcount_d = '0;
          failcount_d = '0;
          ff_valid_d  = 1'b0;
          ff_addr_d   = '0;
          ff_xor_d    = '0;
          state_d     = S_START;
        end
      end
      S_START: begin
        addr_d  = '0;
        lfsr_d  = LFSR_SEED ^ passcount_q;
        inv_d   = passcount_q[0];
        state_d = S_WR;
      end
      S_WR: begin
        if (mem_ack) begin
          if (at_last) begin
            state_d = S_RD_SEED;
          end else begin
            addr_d = addr_q + 1'b1;
            lfsr_d = lfsr_step(lfsr_q);
          end
        end
      end
      S_RD_SEED: begin
        addr_d  = '0;
        lfsr_d  = LFSR_SEED ^ passcount_q;
        state_d = S_RD;
      end
      S_RD: begin
        if (mem_ack) begin
          if (mismatch) begin
            if (failcount_q != 32'hFFFFFFFF) failcount_d = failcount_q + 32'd1;
            if (!ff_valid_q) begin
              ff_valid_d = 1'b1;
              ff_addr_d  = addr_q;
              ff_xor_d   = pat_q ^ mem_rdata;
            end
          end
          if (at_last) begin
            state_d = S_PASS_END;
          end else begin
            addr_d = addr_q + 1'b1;
            lfsr_d = lfsr_step(lfsr_q);
          end
        end
      end
      S_PASS_END: begin
        passcount_d = passcount_q + 32'd1;
        state_d     = run ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_WR) || (state_d == S_RD);
    we_d  = (state_d == S_WR);
    pat_d = req_d ? pattern(mode_d, addr_d, lfsr_d, inv_d) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      run_q       <= 1'b0;
      mode_q      <= '0;
      addr_last_q <= '0;
      addr_q      <= '0;
      lfsr_q      <= '0;
      inv_q       <= 1'b0;
      pat_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      passcount_q <= '0;
      failcount_q <= '0;
      ff_valid_q  <= 1'b0;
      ff_addr_q   <= '0;
      ff_xor_q    <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      mode_q      <= mode_d;
      addr_last_q <= addr_last_d;
      addr_q      <= addr_d;
      lfsr_q      <= lfsr_d;
      inv_q       <= inv_d;
      pat_q       <= pat_d;
      req_q       <= req_d;
      we_q        <= we_d;
      passcount_q <= passcount_d;
      failcount_q <= failcount_d;
      ff_valid_q  <= ff_valid_d;
      ff_addr_q   <= ff_addr_d;
      ff_xor_q    <= ff_xor_d;
    end
  end

  assign mem_req          = req_q;
  assign mem_we           = we_q;
  assign mem_addr         = addr_q;
  assign mem_wdata        = pat_q;
  assign busy             = (state_q != S_IDLE);
  assign passcount        = passcount_q;
  assign failcount        = failcount_q;
  assign first_fail_valid = ff_valid_q;
  assign first_fail_addr  = ff_addr_q;
  assign first_fail_xor   = ff_xor_q;
  assign state            = state_q;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Directed bench for mem_pattern_tester, using a behavioural memory with
// programmable ack delay and an optional stuck-at-0 bit.
module tb_mem_pattern_tester;
  localparam int DW = 16;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [1:0]    mode;
  logic [AW-1:0] addr_last;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, first_fail_valid;
  logic [31:0]   passcount, failcount;
  logic [AW-1:0] first_fail_addr;
  logic [DW-1:0] first_fail_xor;
  logic [3:0]    state;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] wlog [$];
  bit            stuck_en  = 1'b0;
  int            max_delay = 0;

  mem_pattern_tester #(.DATA_W(DW), .ADDR_W(AW), .LFSR_SEED(32'h1D872B41)) dut (
    .clk(clk), .reset(reset), .run(run), .mode(mode), .addr_last(addr_last),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .passcount(passcount),
    .failcount(failcount), .first_fail_valid(first_fail_valid),
    .first_fail_addr(first_fail_addr), .first_fail_xor(first_fail_xor), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pass(input logic [31:0] n, input int budget);
    int k = 0;
    while (passcount !== n && k < budget) begin tick(1); k++; end
    chk("wait_passcount", 64'(passcount), 64'(n));
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget);
    int k = 0;
    while (state !== s && k < budget) begin tick(1); k++; end
    chk("wait_state", 64'(state), 64'(s));
  endtask

  function automatic logic [31:0] sw_lfsr_step(input logic [31:0] v);
    sw_lfsr_step = v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
  endfunction

  // Memory responder: random/zero ack delay, write capture, stability checks.
  initial begin
    bit            have;
    int            cnt;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic          swe;
    have = 1'b0; cnt = 0; sa = '0; sd = '0; swe = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        have = 1'b0;
      end else begin
        if (!have) begin
          have = 1'b1;
          cnt  = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
          sa = mem_addr; sd = mem_wdata; swe = mem_we;
        end else begin
          chk("addr_stable", 64'(mem_addr), 64'(sa));
          chk("wdata_stable", 64'(mem_wdata), 64'(sd));
          chk("we_stable", 64'(mem_we), 64'(swe));
        end
        if (cnt == 0) begin
          mem_ack = 1'b1;
          have    = 1'b0;
          if (mem_we) begin
            mem[mem_addr] = mem_wdata;
            wlog.push_back(mem_wdata);
          end else begin
            mem_rdata = mem[mem_addr];
            if (stuck_en && mem_addr == 8'd5) mem_rdata[3] = 1'b0;
          end
        end else begin
          cnt--;
        end
      end
    end
  end

  initial begin
    logic [31:0] lf;
    reset = 1'b1; run = 1'b0; mode = 2'd0; addr_last = '0;
    tick(3);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pass", 64'(passcount), 64'd0);
    chk("rst_fail", 64'(failcount), 64'd0);
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_ffv", 64'(first_fail_valid), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    reset = 1'b0;
    tick(1);

    // Three passes, mode 0, ideal memory
    mode = 2'd0; addr_last = 8'd7; run = 1'b1;
    wait_pass(32'd2, 3000);
    run = 1'b0;
    wait_state(4'd0, 3000);
    chk("a_pass", 64'(passcount), 64'd3);
    chk("a_fail", 64'(failcount), 64'd0);
    chk("a_busy", 64'(busy), 64'd0);
    chk("a_nwr", 64'(wlog.size()), 64'd24);
    chk("a_w0", 64'(wlog[0]), 64'h0000);
    chk("a_w7", 64'(wlog[7]), 64'h0007);
    chk("a_w8", 64'(wlog[8]), 64'hFFFF);
    chk("a_w15", 64'(wlog[15]), 64'hFFF8);
    chk("a_w16", 64'(wlog[16]), 64'h0000);

    // Stuck bit 3 at address 5; restart clears counters
    wlog.delete(); stuck_en = 1'b1; run = 1'b1;
    tick(3);
    chk("b_clr_pass", 64'(passcount), 64'd0);
    chk("b_busy", 64'(busy), 64'd1);
    chk("b_clr_ffv", 64'(first_fail_valid), 64'd0);
    wait_pass(32'd1, 3000);
    chk("b_fail_p1", 64'(failcount), 64'd0);
    run = 1'b0;
    wait_state(4'd0, 3000);
    chk("b_pass", 64'(passcount), 64'd2);
    chk("b_fail", 64'(failcount), 64'd1);
    chk("b_ffv", 64'(first_fail_valid), 64'd1);
    chk("b_ffaddr", 64'(first_fail_addr), 64'd5);
    chk("b_ffxor", 64'(first_fail_xor), 64'h0008);
    tick(5);
    chk("b_hold_ffv", 64'(first_fail_valid), 64'd1);
    chk("b_hold_fail", 64'(failcount), 64'd1);
    stuck_en = 1'b0;

    // LFSR mode with random ack delays
    wlog.delete(); max_delay = 5; mode = 2'd2; addr_last = 8'd15; run = 1'b1;
    tick(4);
    run = 1'b0;
    wait_state(4'd0, 5000);
    chk("c_pass", 64'(passcount), 64'd1);
    chk("c_fail", 64'(failcount), 64'd0);
    chk("c_nwr", 64'(wlog.size()), 64'd16);
    chk("c_w0", 64'(wlog[0]), 64'h2B41);
    chk("c_w1", 64'(wlog[1]), 64'h95A3);
    lf = 32'h1D872B41;
    for (int k = 0; k < 16; k++) begin
      chk("c_lfsr_seq", 64'(wlog[k]), 64'(lf[15:0]));
      lf = sw_lfsr_step(lf);
    end
    max_delay = 0;

    // Walking one with wrap past DATA_W; mode change mid-pass ignored
    wlog.delete(); mode = 2'd1; addr_last = 8'd17; run = 1'b1;
    tick(4);
    mode = 2'd3; run = 1'b0;
    wait_state(4'd0, 3000);
    chk("d_nwr", 64'(wlog.size()), 64'd18);
    chk("d_w0", 64'(wlog[0]), 64'h0001);
    chk("d_w3", 64'(wlog[3]), 64'h0008);
    chk("d_w15", 64'(wlog[15]), 64'h8000);
    chk("d_w16", 64'(wlog[16]), 64'h0001);
    chk("d_w17", 64'(wlog[17]), 64'h0002);
    chk("d_fail", 64'(failcount), 64'd0);

    // Checkerboard; run dropped during read phase
    wlog.delete(); mode = 2'd3; addr_last = 8'd3; run = 1'b1;
    wait_state(4'd4, 3000);
    run = 1'b0;
    wait_state(4'd0, 3000);
    chk("e_pass", 64'(passcount), 64'd1);
    chk("e_busy", 64'(busy), 64'd0);
    chk("e_fail", 64'(failcount), 64'd0);
    chk("e_w0", 64'(wlog[0]), 64'h5555);
    chk("e_w1", 64'(wlog[1]), 64'hAAAA);

    // Asynchronous reset mid-write
    mode = 2'd0; addr_last = 8'd3; run = 1'b1;
    wait_pass(32'd1, 3000);
    wait_state(4'd2, 100);
    chk("f_wr_req", 64'(mem_req), 64'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("f_req", 64'(mem_req), 64'd0);
    chk("f_state", 64'(state), 64'd0);
    chk("f_pass", 64'(passcount), 64'd0);
    chk("f_busy", 64'(busy), 64'd0);
    run = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);

    // One-word pass
    wlog.delete(); mode = 2'd0; addr_last = 8'd0; run = 1'b1;
    tick(1);
    run = 1'b0;
    wait_state(4'd0, 1000);
    chk("g_pass", 64'(passcount), 64'd1);
    chk("g_nwr", 64'(wlog.size()), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_pattern_tester.md
Name: mem_pattern_tester

Overview:
- Parametrised successor to the SDRAM tester engine.
- Runs continuous write-then-readback passes over a programmable address range with four selectable data patterns.
- Counts completed passes and failed words, and latches the first failing address and data.
- Drives a generic single-outstanding request/ack memory port, so the same tester fronts an SDRAM or DDR controller; its counters feed the on-screen result display.

Parameters:
DATA_W, 16, memory data width (8..64)
ADDR_W, 22, word address width
LFSR_SEED, 32'h1D872B41, base seed for pseudo-random mode (must be nonzero)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
run  in  1  level; rising edge in IDLE starts testing; low stops at end of current pass
mode  in  2  pattern: 0 addr-as-data, 1 walking-one, 2 LFSR, 3 checkerboard
addr_last  in  ADDR_W  last word address tested (range 0..addr_last inclusive)
mem_req  out  1  request valid, held until mem_ack
mem_we  out  1  1 write, 0 read; stable while mem_req
mem_addr  out  ADDR_W  word address; stable while mem_req
mem_wdata  out  DATA_W  write data; stable while mem_req
mem_ack  in  1  one-cycle completion; for reads, mem_rdata valid this cycle
mem_rdata  in  DATA_W  read data
busy  out  1  high when state != IDLE
passcount  out  32  completed passes, wraps
failcount  out  32  mismatched words, saturates at 32'hFFFFFFFF
first_fail_valid  out  1  first mismatch captured since start
first_fail_addr  out  ADDR_W  address of first mismatch
first_fail_xor  out  DATA_W  expected XOR read at first mismatch
state  out  4  encoded FSM state for display

Behaviour:
- Reset (async assert, sync deassert is caller's job): all outputs 0, state IDLE, mem_req dropped immediately, even mid-transaction.
- FSM encoding: IDLE=0, START=1, WR=2, RD_SEED=3, RD=4, PASS_END=5.
- IDLE: on run rising edge (run registered, edge = run & ~run_q), latch mode and addr_last; clear counters and first_fail_*; go START. Changes to mode/addr_last during a run are ignored.
- START (1 cycle): addr<=0; load LFSR with LFSR_SEED ^ passcount; inv<=passcount[0]; go WR.
- WR: assert mem_req, mem_we=1, mem_wdata=pattern(addr). On mem_ack: if addr==addr_last go RD_SEED, else addr+1 and advance LFSR. mem_req may stay high back-to-back; new address/data are presented the cycle after ack.
- RD_SEED (1 cycle): addr<=0, reload LFSR with the same seed. Go RD.
- RD: mem_req=1, mem_we=0. On mem_ack, compare mem_rdata to pattern(addr). On mismatch: failcount+1 (saturating); if !first_fail_valid, capture addr and XOR, set valid. Last address goes PASS_END.
- PASS_END (1 cycle): passcount+1; if run still high go START, else IDLE.
- Patterns, before inversion: mode0 = addr zero-extended/truncated to DATA_W; mode1 = 1 << (addr mod DATA_W); mode2 = LFSR low DATA_W bits (32-bit Galois, taps 32,22,2,1, one step per accepted word, replicated when DATA_W>32); mode3 = addr[0] ? {DATA_W/2{2'b10}} : {DATA_W/2{2'b01}}.
- Inversion: final data = pattern XOR {DATA_W{inv}}, so odd passes use complemented data.
- addr_last=0 gives a one-word pass.
- mem_ack outside WR/RD is ignored.
- failcount and first_fail_* hold their values through IDLE until the next start.

Test Plan:
- DATA_W=16, mode0, addr_last=7, ideal memory model, run held for 3 passes -> passcount=3, failcount=0. Pass 1 writes 0x0000..0x0007; pass 2 writes 0xFFFF..0xFFF8.
- Same setup with memory bit 3 stuck at 0 at address 5 -> pass 1: addr5 expects 0x0005, reads 0x0005, no fail. Pass 2: expects 0xFFFA, reads 0xFFF2 -> failcount=1, first_fail_addr=5, first_fail_xor=0x0008.
- mode2, addr_last=15, ideal memory, random mem_ack delays of 0-5 cycles -> zero fails. mem_addr/mem_wdata are stable while mem_req and unacked; the write sequence matches a software LFSR from seed 32'h1D872B41.
- mode1, DATA_W=8, addr_last=9 -> writes 01,02,04,..,80,01,02. Toggling mode to 3 mid-pass has no effect.
- Drop run during pass 1 RD phase -> pass completes, passcount=1, state returns 0, busy=0. Re-raising run clears counters.
- Assert reset during WR with mem_req high -> mem_req=0 in the same cycle, all counters 0, state=0.
